// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module : display_pkg
//  Brief  : Shared constants, state encoding and helpers for the four-digit
//           seven-segment display scheduler.
//  Rev    : 1.0  initial release
// ============================================================================
//  Contents
//    AN_OFF      all anodes off (active-low)
//    SEG_BLANK   all segments off (active-low)
//    NUM_DIGITS  number of display digits
//    LAST_DIGIT  index of the last digit scanned in a frame
//    ST_GUARD /
//    ST_SHOW     scan state encoding, wrapped by state_t
//    an_select() one-hot-low anode pattern for a digit index
// ============================================================================
package display_pkg;

  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 4;
  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

  localparam logic ST_GUARD = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  typedef enum logic {
    S_GUARD = ST_GUARD,
    S_SHOW  = ST_SHOW
  } state_t;

  // Anode pattern that lights only digit d (active-low).
  function automatic logic [3:0] an_select(input logic [1:0] d);
    logic [3:0] one_hot;
    one_hot   = 4'b0001 << d;
    an_select = ~one_hot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module : hex7seg
//  Brief  : Combinational hex-nibble to seven-segment decoder, full 0-F,
//           active-low outputs ordered {g,f,e,d,c,b,a}.
//  Rev    : 1.0  initial release
// ============================================================================
//  Ports
//    nibble  in   4  hex digit to decode
//    seg     out  7  active-low segment pattern {g,f,e,d,c,b,a}
// ============================================================================
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : seg_display_scheduler
//  Brief  : Time-multiplexes a 16-bit value (four hex digits) onto a
//           four-digit seven-segment display. The value is double-buffered
//           and only swapped at a frame boundary, and every digit slot is
//           preceded by an all-anodes-off guard interval against ghosting.
//  Rev    : 1.0  initial release
// ============================================================================
//  Parameters
//    ON_CYCLES     clkin cycles a digit's anode is driven per slot (>=1)
//    GUARD_CYCLES  clkin cycles all anodes are off before each slot (>=1)
//  Ports
//    clkin       in   1   system clock
//    rst_n       in   1   asynchronous active-low reset
//    data_in     in   16  value to display, digit i = data_in[4i+3:4i]
//    load        in   1   strobe: capture data_in into the shadow register
//    dig_en      in   4   per-digit enable (0 keeps that anode off)
//    dp_in       in   4   per-digit decimal point, active-high
//    blank       in   1   forces all anodes off, sequencing continues
//    seg         out  7   segment cathodes, active-low {g,f,e,d,c,b,a}
//    an          out  4   digit anodes, active-low
//    dp          out  1   decimal-point cathode, active-low
//    frame_tick  out  1   pulse the cycle after each frame boundary
//    load_ack    out  1   pulse the cycle after a shadow->active transfer
// ============================================================================
module seg_display_scheduler
  import display_pkg::*;
#(
  parameter int ON_CYCLES    = 25000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick,
  output logic        load_ack
);

  localparam int MAX_CYCLES = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  // A one-cycle maximum would give a zero-width counter; keep at least one bit.
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Scan sequencing
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;

  // Double-buffered display value
  logic [15:0]      shadow;
  logic [15:0]      active;
  logic             pending;

  // Combinational helpers
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic             guard_end;
  logic             show_end;
  logic             boundary;
  logic             digit_on;

  always_comb begin
    nibble    = active[{digit, 2'b00} +: 4];
    guard_end = (state == S_GUARD) && (cnt == GUARD_LAST);
    show_end  = (state == S_SHOW)  && (cnt == ON_LAST);
    // The frame ends on the last SHOW cycle of the final digit.
    boundary  = show_end && (digit == LAST_DIGIT);
    digit_on  = (state == S_SHOW) && dig_en[digit] && !blank;
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GUARD;
      cnt        <= '0;
      digit      <= 2'd0;
      shadow     <= 16'h0000;
      active     <= 16'h0000;
      pending    <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      // Slot sequencing: counter restarts on every state change.
      case (state)
        S_GUARD: begin
          if (guard_end) begin
            state <= S_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SHOW: begin
          if (show_end) begin
            state <= S_GUARD;
            cnt   <= '0;
            digit <= digit + 2'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_GUARD;
          cnt   <= '0;
        end
      endcase

      // Buffer transfer. A load landing on the boundary cycle goes straight
      // to the active register so it is not deferred by a whole frame.
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shadow <= data_in;
          active <= data_in;
        end else if (pending) begin
          active <= shadow;
        end
      end else if (load) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end

      frame_tick <= boundary;
      load_ack   <= boundary && (load || pending);

      // Outputs follow the current state/digit one cycle later; all three
      // are blanked together whenever no anode is driven.
      an  <= digit_on ? an_select(digit) : AN_OFF;
      seg <= digit_on ? seg_dec : SEG_BLANK;
      dp  <= digit_on ? ~dp_in[digit] : 1'b1;
    end
  end

endmodule
`default_nettype wire
